// File: rtl/riscv_ex_pkg.sv
// Shared RV32I constants and the execute-stage output payload.
package riscv_ex_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned F3_W    = 3;

  localparam logic [F3_W-1:0] FUNCT3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] FUNCT3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] FUNCT3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] FUNCT3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] FUNCT3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] FUNCT3_SRL  = 3'b101;
  localparam logic [F3_W-1:0] FUNCT3_OR   = 3'b110;
  localparam logic [F3_W-1:0] FUNCT3_AND  = 3'b111;

  typedef struct packed {
    logic             memfetch;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  result;
  } ex_out_t;

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32I integer ALU; shifts take their amount from shamt only.
module riscv_alu
  import riscv_ex_pkg::*;
(
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [F3_W-1:0]    funct3,
  input  logic               invertb,
  output logic [XLEN-1:0]    y_c
);

  always_comb begin
    y_c = '0;
    unique case (funct3)
      FUNCT3_ADD:  y_c = invertb ? (a - b) : (a + b);
      FUNCT3_SLL:  y_c = a << shamt;
      FUNCT3_SLT:  y_c = XLEN'($signed(a) < $signed(b));
      FUNCT3_SLTU: y_c = XLEN'(a < b);
      FUNCT3_XOR:  y_c = a ^ b;
      // invertb selects sign fill (SRA) over zero fill (SRL)
      FUNCT3_SRL:  y_c = invertb ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      FUNCT3_OR:   y_c = a | b;
      FUNCT3_AND:  y_c = a & b;
      default:     y_c = '0;
    endcase
  end

endmodule

// File: rtl/riscv_ex.sv
// Execute stage: ALU plus the one-cycle output register toward memory/writeback.
module riscv_ex
  import riscv_ex_pkg::*;
(
  input  logic               rst,
  input  logic               clk,
  input  logic [REG_W-1:0]   rdi,
  input  logic [XLEN-1:0]    a,
  input  logic [XLEN-1:0]    b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [F3_W-1:0]    funct3,
  input  logic               invertb,
  output logic [XLEN-1:0]    result,
  output logic [REG_W-1:0]   rd,
  output logic               memfetch
);

  logic [XLEN-1:0] alu_y_c;
  ex_out_t         ex_d;
  ex_out_t         ex_q;

  riscv_alu u_alu (
    .a       (a),
    .b       (b),
    .shamt   (shamt),
    .funct3  (funct3),
    .invertb (invertb),
    .y_c     (alu_y_c)
  );

  // memfetch stays low until load/store support is added
  always_comb begin
    ex_d          = '0;
    ex_d.result   = alu_y_c;
    ex_d.rd       = rdi;
    ex_d.memfetch = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign result   = ex_q.result;
  assign rd       = ex_q.rd;
  assign memfetch = ex_q.memfetch;

endmodule

// File: tb/tb_riscv_ex.sv
// Scoreboard bench for riscv_ex: driver queues expectations, negedge monitor checks them.
module tb_riscv_ex;
  import riscv_ex_pkg::*;

  logic        rst;
  logic        clk;
  logic [4:0]  rdi;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [2:0]  funct3;
  logic        invertb;
  logic [31:0] result;
  logic [4:0]  rd;
  logic        memfetch;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   edges  = 0;

  riscv_ex dut (
    .rst      (rst),
    .clk      (clk),
    .rdi      (rdi),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .funct3   (funct3),
    .invertb  (invertb),
    .result   (result),
    .rd       (rd),
    .memfetch (memfetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: the DUT presents a new result every cycle; pop whatever is due now
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].due < edges) begin
        exp_t s;
        s = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: result never observed, expected 0x%08h", s.name, s.res);
      end else if (q[0].due == edges) begin
        exp_t e;
        e = q.pop_front();
        check({e.name, ".result"}, result, e.res);
        check({e.name, ".rd"}, 32'(rd), 32'(e.rd));
        check({e.name, ".memfetch"}, 32'(memfetch), 32'd0);
      end
    end
  end

  task automatic drive(input logic [4:0] r, input logic [31:0] va, input logic [31:0] vb,
                       input logic [4:0] sh, input logic [2:0] f3, input logic inv);
    rdi = r; a = va; b = vb; shamt = sh; funct3 = f3; invertb = inv;
  endtask

  task automatic issue(input string name, input logic [4:0] r, input logic [31:0] va,
                       input logic [31:0] vb, input logic [4:0] sh, input logic [2:0] f3,
                       input logic inv, input logic [31:0] exp);
    exp_t e;
    @(posedge clk);
    #2;
    drive(r, va, vb, sh, f3, inv);
    e.res = exp; e.rd = r; e.due = edges + 1; e.name = name;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d expectations left undrained", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(5'd0, 32'd0, 32'd0, 5'd0, FUNCT3_ADD, 1'b0);
    // Asynchronous reset with no clock edge in between (first posedge at t=5)
    #3 rst = 1'b0;
    #1;
    check("reset.result", result, 32'd0);
    check("reset.rd", 32'(rd), 32'd0);
    check("reset.memfetch", 32'(memfetch), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    drive(5'd4, 32'd40, 32'd2, 5'd0, FUNCT3_ADD, 1'b0);
    #1;
    check("release_hold.result", result, 32'd0);
    check("release_hold.rd", 32'(rd), 32'd0);

    issue("add",        5'd4, 32'd40,        32'd2,         5'd0,  FUNCT3_ADD,  1'b0, 32'd42);
    issue("add_neg",    5'd2, 32'd40,        32'hFFFFFFFB,  5'd0,  FUNCT3_ADD,  1'b0, 32'd35);
    issue("sub",        5'd2, 32'd40,        32'd5,         5'd0,  FUNCT3_ADD,  1'b1, 32'd35);
    issue("sub_wrap",   5'd3, 32'd0,         32'd1,         5'd0,  FUNCT3_ADD,  1'b1, 32'hFFFFFFFF);
    issue("sll",        5'd7, 32'd3,         32'd0,         5'd2,  FUNCT3_SLL,  1'b0, 32'd12);
    issue("sll_inv",    5'd8, 32'd1,         32'd9,         5'd4,  FUNCT3_SLL,  1'b1, 32'd16);
    issue("srl",        5'd9, 32'h80000000,  32'hFFFFFFFF,  5'd4,  FUNCT3_SRL,  1'b0, 32'h08000000);
    issue("sra",        5'd10, 32'h80000000, 32'hFFFFFFFF,  5'd4,  FUNCT3_SRL,  1'b1, 32'hF8000000);
    issue("sra31",      5'd11, 32'h80000001, 32'd0,         5'd31, FUNCT3_SRL,  1'b1, 32'hFFFFFFFF);
    issue("srl31",      5'd11, 32'h80000001, 32'd0,         5'd31, FUNCT3_SRL,  1'b0, 32'd1);
    issue("srl_sh0",    5'd12, 32'h12345678, 32'd3,         5'd0,  FUNCT3_SRL,  1'b0, 32'h12345678);
    issue("slt",        5'd13, 32'hFFFFFFFF, 32'd1,         5'd0,  FUNCT3_SLT,  1'b0, 32'd1);
    issue("sltu",       5'd14, 32'hFFFFFFFF, 32'd1,         5'd0,  FUNCT3_SLTU, 1'b0, 32'd0);
    issue("sltu_true",  5'd14, 32'd1,        32'hFFFFFFFF,  5'd0,  FUNCT3_SLTU, 1'b1, 32'd1);
    issue("xor",        5'd15, 32'hF0F0F0F0, 32'h0FF00FF0,  5'd0,  FUNCT3_XOR,  1'b0, 32'hFF00FF00);
    issue("or",         5'd16, 32'hF0F0F0F0, 32'h0FF00FF0,  5'd0,  FUNCT3_OR,   1'b0, 32'hFFF0FFF0);
    issue("or_inv",     5'd17, 32'hF0F0F0F0, 32'h0FF00FF0,  5'd0,  FUNCT3_OR,   1'b1, 32'hFFF0FFF0);
    issue("and",        5'd31, 32'hF0F0F0F0, 32'h0FF00FF0,  5'd0,  FUNCT3_AND,  1'b0, 32'h00F000F0);
    issue("rd_zero",    5'd0, 32'd7,         32'd8,         5'd0,  FUNCT3_ADD,  1'b0, 32'd15);
    drain("stream");

    // Reset asserted ahead of the capturing edge wins over the pending ADD
    @(posedge clk);
    #2;
    drive(5'd9, 32'd40, 32'd2, 5'd0, FUNCT3_ADD, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_async.result", result, 32'd0);
    @(posedge clk);
    #1;
    check("midrst.result", result, 32'd0);
    check("midrst.rd", 32'(rd), 32'd0);
    check("midrst.memfetch", 32'(memfetch), 32'd0);
    #1 rst = 1'b1;
    begin
      exp_t e;
      e.res = 32'd42; e.rd = 5'd9; e.due = edges + 1; e.name = "post_reset_add";
      q.push_back(e);
    end
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out at %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_ex.md
Name: riscv_ex

Overview:
- Execute stage of the in-order RISC-V (RV32I) pipeline.
- Takes decoded operands, the shift amount, funct3 and a modifier bit from decode, and computes the integer ALU result.
- Registers the result together with the destination register index for the memory/writeback stage.
- The memfetch flag is carried for later load/store support.

Parameters:
- none (datapath fixed at 32 bits, register index at 5 bits)

Ports:
(Port order is fixed as listed; instances connect positionally.)
- rst  input  1  asynchronous active-low reset
- clk  input  1  clock, rising-edge
- rdi  input  5  destination register index from decode
- a  input  32  operand A (rs1 value)
- b  input  32  operand B (rs2 value or sign-extended immediate)
- shamt  input  5  shift amount, used by all shift operations
- funct3  input  3  operation select, RV32I funct3 encoding
- invertb  input  1  modifier: subtract for ADD, arithmetic shift for SRL
- result  output  32  registered ALU result
- rd  output  5  registered destination index (rdi delayed one cycle)
- memfetch  output  1  registered memory-access request flag

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst).
- Reset state: while rst=0, result=0, rd=0, memfetch=0 immediately, independent of clk.
- Latency: each rising clk edge with rst=1 captures f(a, b, shamt, funct3, invertb) into result and rdi into rd. Fixed 1-cycle latency, no stall or handshake; every cycle is a valid issue.
- Combinational ALU, funct3 decode:
  - 000 ADD: a+b; with invertb=1, a-b (a + ~b + 1). Modulo 2^32, overflow ignored.
  - 001 SLL: a << shamt, zero fill.
  - 010 SLT: 1 if signed(a) < signed(b), else 0.
  - 011 SLTU: 1 if unsigned(a) < unsigned(b), else 0.
  - 100 XOR: a ^ b.
  - 101 SRL: a >> shamt, zero fill; with invertb=1, SRA (sign fill from a[31]).
  - 110 OR: a | b.
  - 111 AND: a & b.
- invertb is ignored for all funct3 except 000 and 101.
- Shifts never use b; the shift amount comes only from shamt. Decode supplies shamt from the immediate or from rs2[4:0].
- Boundaries:
  - shamt=0 passes a unchanged.
  - shamt=31 with SRA of a negative a gives 0xFFFFFFFF.
  - SLT/SLTU results are zero-extended to 32 bits.
- memfetch: registered, reset 0, driven 0 for every ALU operation in this revision. It is reserved for the load/store extension and must never assert in this revision.
- Reset mid-stream: an asserted rst overrides the pending capture. The first edge after rst deasserts captures the current inputs normally.
- rd = 0 is propagated like any other index; no x0 special-casing here (writeback ignores x0).

Decomposition:
- Shared ISA constants file: FUNCT3_ADD, FUNCT3_SLL, FUNCT3_SLT, FUNCT3_SLTU, FUNCT3_XOR, FUNCT3_SRL, FUNCT3_OR, FUNCT3_AND with the encodings above. Decode and EX both use these; no literal encodings in this block.
- One natural sub-module: riscv_alu. It is purely combinational (a, b, shamt, funct3, invertb -> 32-bit value). riscv_ex wraps it with the output registers and the reset logic.

Test Plan:
- Reset: drive rst=0 -> result=0, rd=0, memfetch=0 without any clk edge. Release rst -> values hold until the next edge.
- ADD: rdi=4, a=40, b=2, shamt=0, funct3=ADD, invertb=0, one edge -> result=42, rd=4, memfetch=0.
- ADD with negative operand: rdi=2, a=40, b=-5 (0xFFFFFFFB), invertb=0 -> result=35, rd=2. Then a=40, b=5, invertb=1 -> result=35.
- SLL uses shamt, not b: rdi=7, a=3, b=0, shamt=2, funct3=SLL -> result=12, rd=7, memfetch=0.
- Shifts and compares:
  - a=0x80000000, shamt=4: SRL -> 0x08000000; SRA (invertb=1) -> 0xF8000000.
  - a=-1, b=1: SLT -> 1, SLTU -> 0.
  - a=0xF0F0F0F0, b=0x0FF00FF0: XOR -> 0xFF00FF00, OR -> 0xFFF0FFF0, AND -> 0x00F000F0.
- Mid-stream reset: issue ADD 40+2 and assert rst before the edge -> outputs remain 0, memfetch=0. Release rst, then one edge -> result=42.
